// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_fifo and instr_fetch_stage.
package rv_fetch_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    // Instruction fetches are word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched entries with flush; head is presented
// combinationally from storage and forced to zero when empty.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    output logic                         head_valid,
    output fetch_entry_t                 head_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign full       = (count == CW'(DEPTH));
    assign head_valid = (count != '0);
    assign head_entry = head_valid ? mem[rd_ptr] : '0;

    // Flush wins over both handshakes; push into a full FIFO needs a pop.
    assign do_pop  = pop & head_valid & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// queues {pc, instr, fault} entries toward decode; redirects flush and reload.
module instr_fetch_stage
    import rv_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault,
    output logic        halted
);

    localparam int unsigned CW         = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(IMEM_WORDS) << 2;

    fetch_state_t     state;
    logic [XLEN-1:0]  pc;
    logic [CW-1:0]    fifo_count;
    logic             pop;
    logic             push;
    logic             can_push;
    logic             fault;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_pc   = pc;
    assign halted    = (state == ST_HALT);
    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;
    assign out_fault = head_entry.fault;

    assign fault    = (pc >= IMEM_BYTES);
    assign pop      = out_valid & out_ready & ~redirect_valid;
    assign can_push = (fifo_count < CW'(DEPTH)) | pop;
    assign push     = (state == ST_RUN) & can_push & ~redirect_valid;

    always_comb begin
        push_entry = '0;
        push_entry.pc = pc;
        if (fault) begin
            push_entry.instr = NOP_INSTR;
            push_entry.fault = 1'b1;
        end else begin
            push_entry.instr = imem_instr;
            push_entry.fault = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_PC;
            state <= ST_RUN;
        end else if (redirect_valid) begin
            pc    <= align_pc(redirect_pc);
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    // A faulting fetch is queued once, then the PC freezes.
                    if (can_push) begin
                        if (fault) begin
                            state <= ST_HALT;
                        end else begin
                            pc <= pc + 64'd4;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_valid (out_valid),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage with a behavioural instruction memory
// whose word i holds 32'h1000_0000 + i.
module tb_instr_fetch_stage;
    import rv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        halted;

    int checks = 0;
    int errors = 0;

    fetch_entry_t sb[$];

    always #5 clk = ~clk;

    assign imem_instr = (imem_pc[63:2] < 62'd1024)
                        ? 32'h1000_0000 + 32'(imem_pc[63:2])
                        : 32'hBADC_0DE5;

    instr_fetch_stage #(
        .RESET_PC   (64'h0),
        .DEPTH      (2),
        .IMEM_WORDS (1024)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic fetch_entry_t mk(input logic [63:0] pc, input logic flt);
        fetch_entry_t e;
        e.pc    = pc;
        e.fault = flt;
        e.instr = flt ? NOP_INSTR : 32'h1000_0000 + 32'(pc[63:2]);
        return e;
    endfunction

    // Compare the head if this cycle is a handshake, then advance one clock.
    task automatic tick();
        fetch_entry_t e;
        if (out_valid && out_ready && !redirect_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk("entry pc", out_pc, e.pc);
            chk("entry instr", out_instr, e.instr);
            chk("entry fault", out_fault, e.fault);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget, output int used);
        used = 0;
        while (sb.size() > 0 && used < budget) begin
            tick();
            used++;
        end
        chk({tag, " drained"}, sb.size(), 0);
    endtask

    initial begin
        int used;
        int seen;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        #2;
        chk("reset out_valid", out_valid, 0);
        chk("reset imem_pc", imem_pc, 64'h0);
        chk("reset out_pc", out_pc, 0);
        chk("reset out_instr", out_instr, 0);
        chk("reset out_fault", out_fault, 0);
        chk("reset halted", halted, 0);

        // 1: stream after reset release
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        chk("t1 valid before edge", out_valid, 0);
        sb.push_back(mk(64'h0, 1'b0));
        sb.push_back(mk(64'h4, 1'b0));
        sb.push_back(mk(64'h8, 1'b0));
        drain("t1", 20, used);
        chk("t1 cycles", used, 4);

        // 2: back-pressure fills the FIFO and stalls the PC
        rst = 1'b0;
        #1;
        rst       = 1'b1;
        out_ready = 1'b0;
        repeat (5) tick();
        chk("t2 stalled imem_pc", imem_pc, 64'h8);
        chk("t2 out_valid", out_valid, 1);
        chk("t2 head pc", out_pc, 64'h0);
        sb.push_back(mk(64'h0, 1'b0));
        sb.push_back(mk(64'h4, 1'b0));
        sb.push_back(mk(64'h8, 1'b0));
        sb.push_back(mk(64'hC, 1'b0));
        out_ready = 1'b1;
        drain("t2", 20, used);
        chk("t2 cycles", used, 4);

        // 3: redirect with queued entries, unaligned target
        out_ready = 1'b0;
        repeat (3) tick();
        chk("t3 queued valid", out_valid, 1);
        sb.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        tick();
        redirect_valid = 1'b0;
        chk("t3 flushed valid", out_valid, 0);
        chk("t3 imem_pc", imem_pc, 64'h100);
        sb.push_back(mk(64'h100, 1'b0));
        sb.push_back(mk(64'h104, 1'b0));
        out_ready = 1'b1;
        drain("t3", 20, used);
        chk("t3 cycles", used, 3);

        // 4: run off the end of memory
        sb.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFC;
        sb.push_back(mk(64'hFFC, 1'b0));
        sb.push_back(mk(64'h1000, 1'b1));
        tick();
        redirect_valid = 1'b0;
        drain("t4", 20, used);
        chk("t4 halted", halted, 1);
        chk("t4 imem_pc frozen", imem_pc, 64'h1000);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("t4 entries after halt", seen, 0);

        // 5: redirect out of HALT
        sb.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h20;
        sb.push_back(mk(64'h20, 1'b0));
        sb.push_back(mk(64'h24, 1'b0));
        tick();
        redirect_valid = 1'b0;
        chk("t5 halted cleared", halted, 0);
        drain("t5", 20, used);

        // 6: asynchronous reset mid-cycle with entries queued
        out_ready = 1'b0;
        repeat (3) tick();
        chk("t6 queued valid", out_valid, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("t6 async out_valid", out_valid, 0);
        chk("t6 async imem_pc", imem_pc, 64'h0);
        chk("t6 async out_pc", out_pc, 0);
        @(posedge clk);
        #1;
        chk("t6 held out_valid", out_valid, 0);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Fetch stage directly upstream of instruction_memory. It owns the architectural PC and drives the memory's PC input, which returns a combinational same-cycle read. Each fetched {pc, instruction} pair is captured into a small FIFO that presents a valid/ready interface to decode. Branch/jump redirects from execute flush the FIFO and reload the PC.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
DEPTH, 2, fetch FIFO entries (power of 2, >=2)
IMEM_WORDS, 1024, instruction memory size in 32-bit words; PCs at or beyond IMEM_WORDS*4 fault

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
imem_pc  output  64  PC driven to instruction memory, equals internal PC register
imem_instr  input  32  instruction returned combinationally for imem_pc
redirect_valid  input  1  execute requests PC change this cycle
redirect_pc  input  64  target PC for redirect
out_valid  output  1  FIFO head valid toward decode
out_ready  input  1  decode accepts head this cycle
out_pc  output  64  PC of head entry
out_instr  output  32  instruction of head entry; 32'h00000013 (NOP) when out_fault=1
out_fault  output  1  head entry is an out-of-range fetch
halted  output  1  stage is in HALT state

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, FIFO empty (count=0, rd/wr ptr=0), state=RUN. Outputs: out_valid=0, out_pc=0, out_instr=0, out_fault=0, halted=0, imem_pc=RESET_PC.
- FIFO: registered storage, count 0..DEPTH, pointers wrap modulo DEPTH. Outputs always reflect the head entry and are zero when empty.
- pop = out_valid & out_ready.
- can_push = (count<DEPTH) | pop. Push while full is allowed only with a same-cycle pop.
- fault = pc >= IMEM_WORDS*4, full 64-bit unsigned compare.
- States:
  - RUN: when no redirect and can_push, push {pc, imem_instr, fault=0} and set pc <= pc+4 (64-bit wrap, no carry-out). If fault, push {pc, NOP, fault=1} instead, leave pc unchanged, and go to HALT. When can_push=0, pc holds (stall).
  - HALT: no pushes; pc holds; halted=1; FIFO continues to drain via pop.
- Redirect, highest priority and valid in any state:
  - Next cycle: FIFO empty, count=0, pc = {redirect_pc[63:2], 2'b00}, state=RUN.
  - No push and no pop take effect that cycle. out_valid may be 1 during the redirect cycle, but the entry is discarded and is not a handshake.
- Latency: redirect at cycle N -> imem_pc=target at N+1, first entry valid at N+2. Steady state: 1 instruction per cycle with out_ready held 1.
- Count update: count_next = count + push - pop. Simultaneous push and pop at full or empty is legal. When empty, push and pop never coincide because out_valid=0.
- imem_pc[1:0] is always 00. Memory index is imem_pc[63:2].
- Reset asserted mid-stream drops all entries immediately. No entry survives reset.

Decomposition:
- Shared package rv_fetch_pkg:
  - NOP_INSTR = 32'h00000013
  - XLEN = 64, ILEN = 32
  - fetch_entry_t = {pc[63:0], instr[31:0], fault}
- One sub-module is natural: fetch_fifo, a parameterised sync FIFO with flush, push/pop, count, and head outputs.
- PC/state logic stays in instr_fetch_stage.

Test Plan:
1. Reset then release, out_ready=1, imem preloaded with word i = 32'h1000_0000+i -> out_valid rises 1 cycle after release. Entries (pc, instr) are (0, 10000000), (4, 10000001), (8, 10000002) on consecutive cycles.
2. out_ready=0 for 5 cycles after release -> FIFO fills to 2 entries and imem_pc holds at 8. Raising out_ready delivers pcs 0, 4, 8 with no gap and no duplicate.
3. Redirect to 64'h103 while 2 entries are queued -> next cycle out_valid=0 and imem_pc=0x100. Following cycle out_pc=0x100 with instr = word 64. Old entries never appear.
4. Redirect to 0xFFC, streaming -> entries 0xFFC (word 1023), then 0x1000 with out_fault=1 and out_instr=NOP. halted=1, and no further entries arrive for 10 cycles.
5. In HALT, redirect to 0x20 -> halted=0 next cycle, and entries resume at 0x20, 0x24.
6. Assert rst mid-cycle with 2 entries queued -> out_valid=0 and imem_pc=RESET_PC immediately, without waiting for a clock edge.
